// File: rtl/cpu_pkg.sv
// Shared opcode, ALU code, state and control-word definitions
// for the CPU control sequencer.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd7;
    localparam logic [4:0] OP_ANDI = 5'd8;
    localparam logic [4:0] OP_ORI  = 5'd9;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_NOP, C_HALT
    } op_class_t;

    typedef struct packed {
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic ba_out;
        logic c_out;
        logic pc_out;
        logic mdr_out;
        logic zlow_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic z_in;
        logic inc_pc;
        logic read;
        logic write;
        logic run;
    } ctrl_t;

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        logic [4:0] a;
        case (op)
            OP_ADD, OP_ADDI: a = ALU_ADD;
            OP_SUB:          a = ALU_SUB;
            OP_AND, OP_ANDI: a = ALU_AND;
            OP_OR, OP_ORI:   a = ALU_OR;
            default:         a = ALU_NOP;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Maps a 5-bit opcode onto the instruction class that picks the
// execute-phase micro-sequence; unknown opcodes fall into the nop class.
module opcode_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = C_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:      op_class = C_IMM;
            OP_LDI:                        op_class = C_LDI;
            OP_LD:                         op_class = C_LD;
            OP_ST:                         op_class = C_ST;
            OP_HALT:                       op_class = C_HALT;
            default:                       op_class = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2, class-dependent execute T3-T7,
// registered control word, memory wait states in T1 / ld-T6 / st-T7.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        mem_ack,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run
);

    state_t    state;
    state_t    nxt;
    op_class_t cls;
    ctrl_t     ctrl;
    logic      rst_hold;
    logic      unused_ir;

    assign unused_ir = ^IR[26:0];

    opcode_class_decode u_dec (
        .opcode   (IR[31:27]),
        .op_class (cls)
    );

    function automatic ctrl_t ctrl_for(
        input state_t    s,
        input op_class_t c,
        input logic      first
    );
        ctrl_t w;
        logic  addr;
        w    = '0;
        addr = (c == C_LDI) || (c == C_LD) || (c == C_ST);
        case (s)
            S_T0: begin
                w.pc_out = 1'b1; w.mar_in = 1'b1;
                w.inc_pc = 1'b1; w.z_in   = 1'b1;
            end
            S_T1: begin
                w.zlow_out = 1'b1; w.pc_in  = first;
                w.read     = 1'b1; w.mdr_in = 1'b1;
            end
            S_T2: begin
                w.mdr_out = 1'b1; w.ir_in = 1'b1;
            end
            S_T3: begin
                w.grb    = 1'b1; w.y_in = 1'b1;
                w.ba_out = addr; w.rout = !addr;
            end
            S_T4: begin
                w.z_in  = 1'b1;
                w.grc   = (c == C_RTYPE);
                w.rout  = (c == C_RTYPE);
                w.c_out = (c != C_RTYPE);
            end
            S_T5: begin
                w.zlow_out = 1'b1;
                w.mar_in   = (c == C_LD) || (c == C_ST);
                w.gra      = !((c == C_LD) || (c == C_ST));
                w.rin      = !((c == C_LD) || (c == C_ST));
            end
            S_T6: begin
                w.mdr_in = 1'b1;
                w.read   = (c == C_LD);
                w.gra    = (c == C_ST);
                w.rout   = (c == C_ST);
            end
            S_T7: begin
                w.write   = (c == C_ST);
                w.mdr_out = (c == C_LD);
                w.gra     = (c == C_LD);
                w.rin     = (c == C_LD);
            end
            default: w = '0;
        endcase
        w.run = (s != S_RESET) && (s != S_HALT);
        return w;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            S_RESET: nxt = S_T0;
            S_T0:    nxt = S_T1;
            S_T1:    nxt = mem_ack ? S_T2 : S_T1;
            S_T2: begin
                if (cls == C_NOP)       nxt = S_T0;
                else if (cls == C_HALT) nxt = S_HALT;
                else                    nxt = S_T3;
            end
            S_T3:    nxt = S_T4;
            S_T4:    nxt = S_T5;
            S_T5:    nxt = (cls == C_LD || cls == C_ST) ? S_T6 : S_T0;
            S_T6: begin
                if (cls == C_LD) nxt = mem_ack ? S_T7 : S_T6;
                else             nxt = S_T7;
            end
            S_T7: begin
                if (cls == C_ST) nxt = mem_ack ? S_T0 : S_T7;
                else             nxt = S_T0;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RESET;
        endcase
    end

    // rst_hold keeps RESET for one full cycle after release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_hold <= 1'b1;
            state    <= S_RESET;
            ctrl     <= '0;
        end else begin
            rst_hold <= 1'b0;
            if (rst_hold) begin
                state <= S_RESET;
                ctrl  <= '0;
            end else begin
                state <= nxt;
                ctrl  <= ctrl_for(nxt, cls, nxt != state);
            end
        end
    end

    always_comb begin
        alu_op = ALU_NOP;
        if (state == S_T0) begin
            alu_op = ALU_ADD;
        end else if (state == S_T4) begin
            if (cls == C_RTYPE || cls == C_IMM) alu_op = alu_of(IR[31:27]);
            else                                alu_op = ALU_ADD;
        end
    end

    assign Gra     = ctrl.gra;
    assign Grb     = ctrl.grb;
    assign Grc     = ctrl.grc;
    assign Rin     = ctrl.rin;
    assign Rout    = ctrl.rout;
    assign BAout   = ctrl.ba_out;
    assign Cout    = ctrl.c_out;
    assign PCout   = ctrl.pc_out;
    assign MDRout  = ctrl.mdr_out;
    assign Zlowout = ctrl.zlow_out;
    assign PCin    = ctrl.pc_in;
    assign IRin    = ctrl.ir_in;
    assign MARin   = ctrl.mar_in;
    assign MDRin   = ctrl.mdr_in;
    assign Yin     = ctrl.y_in;
    assign Zin     = ctrl.z_in;
    assign IncPC   = ctrl.inc_pc;
    assign Read    = ctrl.read;
    assign Write   = ctrl.write;
    assign Run     = ctrl.run;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none; all opcodes and ALU codes come from the shared package.
REQ-002 clk  in  1  single system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 IR  in  32  instruction register contents; opcode = IR[31:27].
REQ-005 mem_ack  in  1  memory handshake; high for the cycle in which a Read or Write completes.
REQ-006 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select controls driving the select/encode stage.
REQ-007 Cout, PCout, MDRout, Zlowout  out  1 each  bus-source enables.
REQ-008 PCin, IRin, MARin, MDRin, Yin, Zin  out  1 each  register load enables.
REQ-009 IncPC  out  1  ALU computes PC+1 this cycle.
REQ-010 Read, Write  out  1 each  memory strobes.
REQ-011 alu_op  out  5  ALU operation code.
REQ-012 Run  out  1  high while executing; low in RESET and HALT.

Function
REQ-013 The block SHALL be a Moore FSM; every output SHALL be a function of the present state only, except alu_op, which also depends on IR[31:27].
REQ-014 States: RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
REQ-015 RESET SHALL drive all outputs 0 and advance to T0 on the next edge.
REQ-016 T0: PCout, MARin, IncPC, Zin.
REQ-017 T1: Zlowout, PCin, Read, MDRin. The FSM SHALL hold T1 until mem_ack=1, and SHALL assert PCin only in the first T1 cycle.
REQ-018 T2: MDRout, IRin.
REQ-019 After T2, decode the IR opcode: nop -> T0; halt -> HALT; all other valid opcodes -> T3.
REQ-020 R-type (add, sub, and, or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, with alu_op = the opcode's operation.
  - T5: Zlowout, Gra, Rin, then T0.
REQ-021 Immediate (addi, andi, ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, with alu_op = the operation.
  - T5: Zlowout, Gra, Rin, then T0.
REQ-022 ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, with alu_op = ADD.
  - T5: Zlowout, Gra, Rin, then T0.
REQ-023 ld:
  - T3 and T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; hold until mem_ack=1.
  - T7: MDRout, Gra, Rin, then T0.
REQ-024 st:
  - T3 to T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write; hold until mem_ack=1, then T0.
REQ-025 While a wait state is held, Read or Write SHALL stay high continuously. mem_ack SHALL be ignored in every state other than T1, ld-T6 and st-T7.
REQ-026 An undefined opcode SHALL be executed as nop (T2 -> T0).
REQ-027 HALT SHALL drive all outputs 0 and be left only by reset.
REQ-028 alu_op SHALL be the package NOP code in every state except T0 (ADD, for IncPC) and T4.
REQ-029 At most one bus-source enable (Rout, BAout, Cout, PCout, MDRout, Zlowout) SHALL be high in any state.

Reset
REQ-030 reset=1 SHALL force state RESET and all outputs 0 asynchronously, including mid-instruction and during a memory wait.
REQ-031 On reset release, the first active-output state SHALL be T0, exactly two rising edges later.

Structure
REQ-032 A shared package, cpu_pkg, SHALL hold the 5-bit opcode constants, the alu_op codes and the state enumeration.
REQ-033 One sub-module, opcode_class_decode (maps opcode to class: RTYPE, IMM, LDI, LD, ST, NOP, HALT), is natural. All other logic SHALL be in control_sequencer.

Verification
REQ-034 Fetch: reset release, mem_ack=1 on the first T1 cycle -> sequence RESET, T0, T1, T2. PCin SHALL be high for exactly one cycle and IRin high in T2.
REQ-035 add R1,R2,R3 (IR=0x18918000) -> T3 Grb+Rout+Yin; T4 Grc+Rout+Zin with alu_op=ADD; T5 Gra+Rin; then T0.
REQ-036 ld R2,0x55(R1) with mem_ack delayed 3 cycles in T6 -> Read high for 3 consecutive cycles, and MDRout+Gra+Rin in T7.
REQ-037 st with mem_ack never asserted -> the FSM stays in T7 with Write=1. Asserting reset then drives all outputs to 0 within the same cycle.
REQ-038 halt opcode -> HALT with Run=0; HALT persists for 20 cycles with mem_ack toggling; reset recovers the FSM to T0.
REQ-039 Undefined opcode 0x1F -> T2 goes directly to T0, with no Rin/Write pulse.
